// File: rtl/rv_mem_arb.sv
// rtl/rv_mem_arb.sv - shared memory port arbiter/sequencer for fetch and data access (optional RV_MEM_ARB_PERF_EN stall counters)
module rv_mem_arb #(
  parameter int unsigned MAX_DM_BURST = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic [31:0] o_if_rdata,
  output logic        o_if_ack,
  input  logic        i_dm_req,
  input  logic        i_dm_we,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  input  logic [2:0]  i_dm_bytectrl,
  output logic [31:0] o_dm_rdata,
  output logic        o_dm_ack,
  output logic        o_bus_valid,
  input  logic        i_bus_ready,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [2:0]  o_bus_bytectrl,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata,
  output logic        o_busy,
  output logic [31:0] o_perf_if_stall,
  output logic [31:0] o_perf_dm_stall
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0] BURST_MAX = 4'(MAX_DM_BURST);
  localparam logic [2:0] BC_WORD   = 3'b010;

  logic [1:0]  state_q, state_d;
  logic        owner_if_q, owner_if_d;
  logic [3:0]  burst_q, burst_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [2:0]  bus_bc_q, bus_bc_d;
  logic [31:0] rdata_q, rdata_d;

  logic dm_wins;
  // Fetch has been passed over often enough: it must take this arbitration.
  assign dm_wins = i_dm_req && !(i_if_req && (burst_q == BURST_MAX));

  // Next-state: arbitration and capture in IDLE, then handshake sequencing.
  always_comb begin
    state_d     = state_q;
    owner_if_d  = owner_if_q;
    burst_d     = burst_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_bc_d    = bus_bc_q;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (dm_wins) begin
          owner_if_d  = 1'b0;
          bus_we_d    = i_dm_we;
          bus_addr_d  = i_dm_addr;
          bus_wdata_d = i_dm_wdata;
          bus_bc_d    = i_dm_bytectrl;
          if (!i_if_req) begin
            burst_d = 4'd0;
          end else if (burst_q != BURST_MAX) begin
            burst_d = burst_q + 4'd1;
          end
          state_d = S_ISSUE;
        end else if (i_if_req) begin
          owner_if_d  = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = i_if_addr;
          bus_wdata_d = 32'd0;
          bus_bc_d    = BC_WORD;
          burst_d     = 4'd0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: if (i_bus_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (i_bus_rvalid) begin
          // Stores return no data; their response only completes the access.
          rdata_d = bus_we_q ? 32'd0 : i_bus_rdata;
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured transaction registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      owner_if_q  <= 1'b0;
      burst_q     <= 4'd0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_bc_q    <= 3'd0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      owner_if_q  <= owner_if_d;
      burst_q     <= burst_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_bc_q    <= bus_bc_d;
      rdata_q     <= rdata_d;
    end
  end

  assign o_bus_valid    = (state_q == S_ISSUE);
  assign o_bus_we       = bus_we_q;
  assign o_bus_addr     = bus_addr_q;
  assign o_bus_wdata    = bus_wdata_q;
  assign o_bus_bytectrl = bus_bc_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_if_ack       = (state_q == S_RESP) && owner_if_q;
  assign o_dm_ack       = (state_q == S_RESP) && !owner_if_q;
  assign o_if_rdata     = o_if_ack ? rdata_q : 32'd0;
  assign o_dm_rdata     = o_dm_ack ? rdata_q : 32'd0;

`ifdef RV_MEM_ARB_PERF_EN
  logic [31:0] perf_if_q, perf_dm_q;

  // Saturating counts of cycles a requester waits without completion.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      perf_if_q <= 32'd0;
      perf_dm_q <= 32'd0;
    end else begin
      if (i_if_req && !o_if_ack && (perf_if_q != 32'hFFFF_FFFF)) perf_if_q <= perf_if_q + 32'd1;
      if (i_dm_req && !o_dm_ack && (perf_dm_q != 32'hFFFF_FFFF)) perf_dm_q <= perf_dm_q + 32'd1;
    end
  end

  assign o_perf_if_stall = perf_if_q;
  assign o_perf_dm_stall = perf_dm_q;
`else
  assign o_perf_if_stall = 32'd0;
  assign o_perf_dm_stall = 32'd0;
`endif

endmodule

// File: tb/tb_rv_mem_arb.sv
// tb/tb_rv_mem_arb.sv - directed plus randomized bench for rv_mem_arb against a transaction-level model
module tb_rv_mem_arb;
  localparam int MAXB = 4;

  logic clk, rst;
  logic i_if_req, i_dm_req, i_dm_we, i_bus_ready, i_bus_rvalid;
  logic [31:0] i_if_addr, i_dm_addr, i_dm_wdata, i_bus_rdata;
  logic [2:0] i_dm_bytectrl;
  logic [31:0] o_if_rdata, o_dm_rdata, o_bus_addr, o_bus_wdata, o_perf_if_stall, o_perf_dm_stall;
  logic o_if_ack, o_dm_ack, o_bus_valid, o_bus_we, o_busy;
  logic [2:0] o_bus_bytectrl;

  rv_mem_arb #(.MAX_DM_BURST(MAXB)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rdata(o_if_rdata), .o_if_ack(o_if_ack),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
    .i_dm_bytectrl(i_dm_bytectrl), .o_dm_rdata(o_dm_rdata), .o_dm_ack(o_dm_ack),
    .o_bus_valid(o_bus_valid), .i_bus_ready(i_bus_ready), .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_bytectrl(o_bus_bytectrl),
    .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata), .o_busy(o_busy),
    .o_perf_if_stall(o_perf_if_stall), .o_perf_dm_stall(o_perf_dm_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: where the single outstanding access is
  // (offered / awaiting response / completing) and what it should carry.
  bit m_offer, m_wait, m_ack, m_own_if;
  logic m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0] m_bc;
  int m_passed;
  logic [31:0] exp_perf_if, exp_perf_dm;
  bit prev_valid;
  bit seq_q[$];

  task automatic model_reset();
    m_offer = 0; m_wait = 0; m_ack = 0; m_own_if = 0; m_passed = 0;
    exp_perf_if = 0; exp_perf_dm = 0; prev_valid = 0;
  endtask

  task automatic model_step();
    bit if_done, dm_done;
    if_done = m_ack && m_own_if;
    dm_done = m_ack && !m_own_if;
    if (i_if_req && !if_done && exp_perf_if != 32'hFFFF_FFFF) exp_perf_if++;
    if (i_dm_req && !dm_done && exp_perf_dm != 32'hFFFF_FFFF) exp_perf_dm++;
    if (m_ack) m_ack = 0;
    else if (m_offer) begin
      if (i_bus_ready) begin m_offer = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (i_bus_rvalid) begin m_wait = 0; m_ack = 1; m_rdata = m_we ? 32'd0 : i_bus_rdata; end
    end else if (i_dm_req && !(i_if_req && m_passed >= MAXB)) begin
      m_offer = 1; m_own_if = 0;
      m_we = i_dm_we; m_addr = i_dm_addr; m_wdata = i_dm_wdata; m_bc = i_dm_bytectrl;
      m_passed = i_if_req ? m_passed + 1 : 0;
    end else if (i_if_req) begin
      m_offer = 1; m_own_if = 1;
      m_we = 0; m_addr = i_if_addr; m_wdata = 0; m_bc = 3'b010;
      m_passed = 0;
    end
  endtask

  task automatic check_outputs();
    bit a_if, a_dm;
    a_if = m_ack && m_own_if;
    a_dm = m_ack && !m_own_if;
    check_eq("bus_valid", 32'(o_bus_valid), 32'(m_offer));
    if (m_offer) begin
      check_eq("bus_addr", o_bus_addr, m_addr);
      check_eq("bus_we", 32'(o_bus_we), 32'(m_we));
      check_eq("bus_wdata", o_bus_wdata, m_wdata);
      check_eq("bus_bytectrl", 32'(o_bus_bytectrl), 32'(m_bc));
    end
    check_eq("busy", 32'(o_busy), 32'(m_offer | m_wait | m_ack));
    check_eq("if_ack", 32'(o_if_ack), 32'(a_if));
    check_eq("dm_ack", 32'(o_dm_ack), 32'(a_dm));
    check_eq("if_rdata", o_if_rdata, a_if ? m_rdata : 32'd0);
    check_eq("dm_rdata", o_dm_rdata, a_dm ? m_rdata : 32'd0);
`ifdef RV_MEM_ARB_PERF_EN
    check_eq("perf_if", o_perf_if_stall, exp_perf_if);
    check_eq("perf_dm", o_perf_dm_stall, exp_perf_dm);
`else
    check_eq("perf_if_off", o_perf_if_stall, 32'd0);
    check_eq("perf_dm_off", o_perf_dm_stall, 32'd0);
`endif
    if (o_bus_valid && !prev_valid) seq_q.push_back(o_bus_addr == 32'h0000_0200);
    prev_valid = o_bus_valid;
  endtask

  // One clock: the model consumes this cycle's inputs, then outputs are compared mid-cycle.
  task automatic tick();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_ack(input string tag, input bit want_if, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (m_ack && (m_own_if == want_if)) break;
    end
    check_eq(tag, 32'(want_if ? o_if_ack : o_dm_ack), 32'd1);
  endtask

  task automatic drain();
    i_bus_ready = 1; i_bus_rvalid = 1;
    for (int i = 0; i < 20 && (m_offer || m_wait || m_ack); i++) tick();
    i_bus_rvalid = 0;
    tick();
    check_eq("drain_idle", 32'(o_busy), 32'd0);
  endtask

  logic [31:0] perf_base;
  int exp_seq[6] = '{0, 0, 0, 0, 1, 0};

  initial begin
    rst = 1;
    i_if_req = 0; i_if_addr = 0; i_dm_req = 0; i_dm_we = 0; i_dm_addr = 0;
    i_dm_wdata = 0; i_dm_bytectrl = 0; i_bus_ready = 0; i_bus_rvalid = 0; i_bus_rdata = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_addr", o_bus_addr, 32'd0);
    check_eq("rst_bc", 32'(o_bus_bytectrl), 32'd0);
    check_outputs();
    rst = 0;

    // IF-only read, minimum latency.
    i_if_req = 1; i_if_addr = 32'h0000_0400;
    tick();
    check_eq("tp1_bc", 32'(o_bus_bytectrl), 32'd2);
    check_eq("tp1_we", 32'(o_bus_we), 32'd0);
    i_bus_ready = 1;
    tick();
    i_bus_ready = 0; i_bus_rvalid = 1; i_bus_rdata = 32'h0000_0013;
    tick();
    check_eq("tp1_ack", 32'(o_if_ack), 32'd1);
    check_eq("tp1_rdata", o_if_rdata, 32'h0000_0013);
    i_if_req = 0; i_bus_rvalid = 0;
    tick();

    // Simultaneous IF and DM store: DM first, then IF.
    i_if_req = 1; i_if_addr = 32'h0000_0404;
    i_dm_req = 1; i_dm_we = 1; i_dm_addr = 32'h0000_0100; i_dm_wdata = 32'hDEAD_BEEF; i_dm_bytectrl = 3'b010;
    i_bus_ready = 1; i_bus_rvalid = 1; i_bus_rdata = 32'h1234_5678;
    tick();
    check_eq("tp2_addr", o_bus_addr, 32'h0000_0100);
    check_eq("tp2_we", 32'(o_bus_we), 32'd1);
    check_eq("tp2_wdata", o_bus_wdata, 32'hDEAD_BEEF);
    wait_ack("tp2_dm_ack", 0, 10);
    check_eq("tp2_dm_rdata", o_dm_rdata, 32'd0);
    i_dm_req = 0;
    wait_ack("tp2_if_ack", 1, 10);
    i_if_req = 0;
    drain();

    // Starvation guard: IF held, DM always pending.
    seq_q.delete();
    i_if_req = 1; i_if_addr = 32'h0000_0200;
    i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h8000_0100; i_dm_bytectrl = 3'b000;
    i_bus_ready = 1; i_bus_rvalid = 1;
    for (int i = 0; i < 100 && seq_q.size() < 6; i++) begin
      tick();
      if (m_ack && m_own_if) i_if_req = 0;
    end
    i_if_req = 0; i_dm_req = 0;
    drain();
    check_eq("burst_len", 32'(seq_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < seq_q.size(); i++)
      check_eq($sformatf("burst_seq%0d", i), 32'(seq_q[i]), 32'(exp_seq[i]));

    // Bus not ready for 5 cycles; rvalid during ISSUE is ignored.
    i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h8000_0040; i_dm_bytectrl = 3'b100;
    i_bus_ready = 0; i_bus_rvalid = 1; i_bus_rdata = 32'h0000_0055;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_valid", 32'(o_bus_valid), 32'd1);
      check_eq("stall_addr", o_bus_addr, 32'h8000_0040);
    end
    i_bus_ready = 1;
    tick();
    check_eq("stall_noack", 32'(o_dm_ack), 32'd0);
    i_bus_ready = 0; i_bus_rvalid = 0;
    tick();
    i_bus_rvalid = 1; i_bus_rdata = 32'hCAFE_0001;
    tick();
    check_eq("stall_ack", 32'(o_dm_ack), 32'd1);
    check_eq("stall_rdata", o_dm_rdata, 32'hCAFE_0001);
    i_dm_req = 0; i_bus_rvalid = 0;
    tick();

    // IF read with ready at +2 and rvalid at +2: five stalled cycles.
    perf_base = exp_perf_if;
    i_if_req = 1; i_if_addr = 32'h0000_0800;
    tick();
    tick();
    i_bus_ready = 1;
    tick();
    i_bus_ready = 0;
    tick();
    i_bus_rvalid = 1; i_bus_rdata = 32'h0000_0777;
    tick();
    check_eq("perf_ack", 32'(o_if_ack), 32'd1);
    i_if_req = 0; i_bus_rvalid = 0;
    tick();
`ifdef RV_MEM_ARB_PERF_EN
    check_eq("perf_delta", o_perf_if_stall, perf_base + 32'd5);
`else
    check_eq("perf_delta", o_perf_if_stall, 32'd0);
`endif

    // Reset while waiting for the response.
    i_if_req = 1; i_if_addr = 32'h0000_0C00; i_bus_ready = 1; i_bus_rvalid = 0;
    tick();
    tick();
    #2 rst = 1;
    #1;
    check_eq("rstw_busy", 32'(o_busy), 32'd0);
    check_eq("rstw_valid", 32'(o_bus_valid), 32'd0);
    check_eq("rstw_addr", o_bus_addr, 32'd0);
    check_eq("rstw_ack", 32'(o_if_ack | o_dm_ack), 32'd0);
    i_if_req = 0;
    model_reset();
    @(negedge clk);
    rst = 0;
    check_outputs();
    i_bus_rvalid = 1; i_bus_rdata = 32'hBAD0_BAD0;
    repeat (3) tick();
    i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h8000_0080;
    wait_ack("rstw_fresh", 0, 10);
    i_dm_req = 0;
    drain();

    // Randomized traffic with a random bus.
    for (int c = 0; c < 3000; c++) begin
      if (m_ack && m_own_if) i_if_req = $urandom_range(1, 0);
      else if ((m_offer || m_wait) && m_own_if && $urandom_range(9, 0) == 0) i_if_addr = $urandom;
      if (m_ack && !m_own_if) i_dm_req = $urandom_range(1, 0);
      else if ((m_offer || m_wait) && !m_own_if && $urandom_range(9, 0) == 0) i_dm_wdata = $urandom;
      if ((m_ack && m_own_if) || (!i_if_req && $urandom_range(3, 0) == 0)) begin
        if (!(m_ack && m_own_if)) i_if_req = 1;
        i_if_addr = {1'b0, 29'($urandom), 2'b00};
      end
      if ((m_ack && !m_own_if) || (!i_dm_req && $urandom_range(3, 0) == 0)) begin
        if (!(m_ack && !m_own_if)) i_dm_req = 1;
        i_dm_addr = {1'b1, 31'($urandom)};
        i_dm_we = 1'($urandom);
        i_dm_wdata = $urandom;
        i_dm_bytectrl = 3'($urandom);
      end
      i_bus_ready = 1'($urandom);
      i_bus_rvalid = ($urandom_range(2, 0) == 0);
      i_bus_rdata = $urandom;
      tick();
    end
    i_if_req = 0; i_dm_req = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
